chunked_serial_adder: RTL and testbench

- Multi-cycle, parametrised successor to the 1-bit full adder in the adder_8bit project.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, using one CHUNK-bit adder slice and a registered carry.
- A start/busy/done handshake runs it, so a small-area datapath can drive it directly.

---
 rtl/chunked_serial_adder_if.sv | 25 ++
 rtl/chunked_serial_adder.sv | 144 ++++++++++++++
 tb/tb_chunked_serial_adder.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chunked_serial_adder_if.sv
// Handshake and data bundle for chunked_serial_adder: a requester drives the
// start strobe and operands, the adder returns busy/done and the result flags.
interface chunked_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out, overflow
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out, overflow
    );
endinterface

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: adds two WIDTH-bit operands plus a carry-in, CHUNK bits
// per clock, through one CHUNK-bit adder slice and a registered carry. A
// start/busy/done handshake sequences the operation; results are held from the
// done cycle until the next accepted start.
module chunked_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    chunked_serial_adder_if.slave bus
);
    localparam int NCH   = WIDTH / CHUNK;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NCH - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    int               shamt;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [CHUNK:0]   slice_res;
    logic [WIDTH-1:0] sum_ins;
    logic             msb_ovf;

    // One CHUNK-bit adder slice; the top bit of the result is the slice carry-out.
    function automatic logic [CHUNK:0] add_slice(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             cin
    );
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    endfunction

    // Slice datapath: pick chunk cnt_q of the latched operands, add, and merge into sum.
    always_comb begin
        shamt     = int'(cnt_q) * CHUNK;
        a_shift   = a_q >> shamt;
        b_shift   = b_q >> shamt;
        slice_res = add_slice(a_shift[CHUNK-1:0], b_shift[CHUNK-1:0], carry_q);
        sum_ins   = (sum_q & ~(CHUNK_MASK << shamt))
                  | (WIDTH'(slice_res[CHUNK-1:0]) << shamt);
        // Only meaningful on the last chunk, where slice bit CHUNK-1 is the sum MSB.
        msb_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                  && (slice_res[CHUNK-1] != a_q[WIDTH-1]);
    end

    // Next-state logic: RUN walks the chunks, DONE lasts one cycle, start restarts from IDLE or DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        accept  = bus.start && (state_q != RUN);

        case (state_q)
            RUN: begin
                sum_d   = sum_ins;
                carry_d = slice_res[CHUNK];
                if (cnt_q == LAST_CNT) begin
                    c_out_d = slice_res[CHUNK];
                    ovf_d   = msb_ovf;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new request wins over the DONE->IDLE return, giving back-to-back operation.
        if (accept) begin
            state_d = RUN;
            a_d     = bus.a;
            b_d     = bus.b;
            carry_d = bus.c_in;
            cnt_d   = '0;
            sum_d   = '0;
            c_out_d = 1'b0;
            ovf_d   = 1'b0;
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Control and result registers; reset aborts any operation and clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Operand latch; only an accepted start loads new values, so inputs may move during RUN.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.c_out    = c_out_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: five configurations run side by side against a
// behavioural model (operation occupies NCH edges, result = plain integer sum).
// Configuration 1 (WIDTH=8, CHUNK=2) also runs a directed sequence with literal results.
module tb_chunked_serial_adder;
    localparam int NCFG       = 5;
    localparam int MAXW       = 16;
    localparam int NOPS       = 1000;
    localparam int DIRG       = 1;
    localparam int RAND_LIMIT = 30000;

    function automatic int cfg_w(input int g);
        return (g == 4) ? 16 : 8;
    endfunction

    function automatic int cfg_c(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            3:       return 8;
            default: return 4;
        endcase
    endfunction

    function automatic int nch_of(input int g);
        return cfg_w(g) / cfg_c(g);
    endfunction

    // Reference: {overflow, c_out, sum} from integer arithmetic on the w-bit operands.
    function automatic logic [MAXW+1:0] ref_add(input int w, input logic [MAXW-1:0] a,
                                                input logic [MAXW-1:0] b, input logic cin);
        longint m, ua, ub, us, sa, sb, ss;
        logic [MAXW+1:0] r;
        m  = longint'(1) <<< w;
        ua = longint'(a) % m;
        ub = longint'(b) % m;
        us = ua + ub + longint'(cin);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        ss = sa + sb + longint'(cin);
        r  = '0;
        r[MAXW-1:0] = MAXW'(us % m);
        r[MAXW]     = (us >= m);
        r[MAXW+1]   = (ss >= m / 2) || (ss < -(m / 2));
        return r;
    endfunction

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NCFG-1:0]           start_v;
    logic [NCFG-1:0][MAXW-1:0] a_v;
    logic [NCFG-1:0][MAXW-1:0] b_v;
    logic [NCFG-1:0]           cin_v;
    logic [NCFG-1:0]           busy_v;
    logic [NCFG-1:0]           done_v;
    logic [NCFG-1:0][MAXW-1:0] sum_v;
    logic [NCFG-1:0]           cout_v;
    logic [NCFG-1:0]           ovf_v;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W = cfg_w(g);
        localparam int C = cfg_c(g);
        chunked_serial_adder_if #(.WIDTH(W)) bus_i ();
        chunked_serial_adder #(.WIDTH(W), .CHUNK(C)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus_i)
        );
        assign bus_i.start = start_v[g];
        assign bus_i.a     = a_v[g][W-1:0];
        assign bus_i.b     = b_v[g][W-1:0];
        assign bus_i.c_in  = cin_v[g];
        assign busy_v[g]   = bus_i.busy;
        assign done_v[g]   = bus_i.done;
        assign sum_v[g]    = MAXW'(bus_i.sum);
        assign cout_v[g]   = bus_i.c_out;
        assign ovf_v[g]    = bus_i.overflow;
    end

    // ---------------- behavioural model ----------------
    int              cyc = 0;
    int              rem      [NCFG];
    int              acc_cyc  [NCFG];
    int              ops      [NCFG];
    logic [NCFG-1:0] exp_done;
    logic [MAXW+1:0] exp_res  [NCFG];
    logic [MAXW+1:0] pend_res [NCFG];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < NCFG; g++) begin
            if (rst) begin
                rem[g]      <= 0;
                exp_done[g] <= 1'b0;
                exp_res[g]  <= '0;
            end else if (start_v[g] && rem[g] == 0) begin
                rem[g]      <= nch_of(g);
                exp_done[g] <= 1'b0;
                exp_res[g]  <= '0;
                pend_res[g] <= ref_add(cfg_w(g), a_v[g], b_v[g], cin_v[g]);
                acc_cyc[g]  <= cyc + 1;
            end else if (rem[g] > 0) begin
                rem[g]      <= rem[g] - 1;
                exp_done[g] <= (rem[g] == 1);
                if (rem[g] == 1) begin
                    exp_res[g] <= pend_res[g];
                    ops[g]     <= ops[g] + 1;
                end
            end else begin
                exp_done[g] <= 1'b0;
            end
        end
    end

    // ---------------- shared state between stimulus and compare ----------------
    logic [7:0] lit_sum  [16];
    logic       lit_cout [16];
    logic       lit_ovf  [16];
    int         lit_acc  [16];
    int         lit_wr;
    int         lit_rd = 0;
    int         tmo_cnt;
    int         zchk_cyc;
    logic       chk_en;
    logic       end_req;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d cycle %0d: got %0h expected %0h", nm, g, cyc, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    initial begin : compare
        forever begin
            @(negedge clk);
            if (end_req) begin
                for (int g = 0; g < NCFG; g++)
                    chk("ops_completed", g, 32'(ops[g] >= NOPS), 32'd1);
                chk("wait_timeouts", DIRG, tmo_cnt, 0);
                chk("literal_ops_seen", DIRG, lit_rd, lit_wr);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
            if (chk_en) begin
                for (int g = 0; g < NCFG; g++) begin
                    chk("busy", g, busy_v[g], rem[g] > 0);
                    chk("done", g, done_v[g], exp_done[g]);
                    if (rem[g] == 0) begin
                        chk("sum", g, sum_v[g], exp_res[g][MAXW-1:0]);
                        chk("c_out", g, cout_v[g], exp_res[g][MAXW]);
                        chk("overflow", g, ovf_v[g], exp_res[g][MAXW+1]);
                    end
                    if (done_v[g])
                        chk("latency", g, cyc - acc_cyc[g], nch_of(g));
                end
                if (cyc == zchk_cyc) begin
                    chk("rst_busy", DIRG, busy_v[DIRG], 0);
                    chk("rst_done", DIRG, done_v[DIRG], 0);
                    chk("rst_sum", DIRG, sum_v[DIRG], 0);
                    chk("rst_c_out", DIRG, cout_v[DIRG], 0);
                    chk("rst_overflow", DIRG, ovf_v[DIRG], 0);
                end
                if (exp_done[DIRG] && lit_rd != lit_wr) begin
                    chk("lit_sum", DIRG, sum_v[DIRG], lit_sum[lit_rd]);
                    chk("lit_c_out", DIRG, cout_v[DIRG], lit_cout[lit_rd]);
                    chk("lit_overflow", DIRG, ovf_v[DIRG], lit_ovf[lit_rd]);
                    chk("model_sum", DIRG, exp_res[DIRG][MAXW-1:0], lit_sum[lit_rd]);
                    chk("model_c_out", DIRG, exp_res[DIRG][MAXW], lit_cout[lit_rd]);
                    chk("model_overflow", DIRG, exp_res[DIRG][MAXW+1], lit_ovf[lit_rd]);
                    chk("lit_latency", DIRG, cyc - lit_acc[lit_rd], 4);
                    lit_rd++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic cin);
        a_v[DIRG]     = MAXW'(a);
        b_v[DIRG]     = MAXW'(b);
        cin_v[DIRG]   = cin;
        start_v[DIRG] = 1'b1;
    endtask

    task automatic expect_lit(input logic [7:0] s, input logic co, input logic ov);
        lit_sum[lit_wr]  = s;
        lit_cout[lit_wr] = co;
        lit_ovf[lit_wr]  = ov;
        lit_acc[lit_wr]  = cyc + 1;
        lit_wr++;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_v[DIRG] && n < 20) begin
            step();
            n++;
        end
        if (!done_v[DIRG]) tmo_cnt++;
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] s, input logic co, input logic ov);
        launch(a, b, cin);
        expect_lit(s, co, ov);
        step();
        start_v[DIRG] = 1'b0;
        wait_done();
        step();
    endtask

    function automatic bit all_ops_done();
        for (int g = 0; g < NCFG; g++)
            if (ops[g] < NOPS) return 1'b0;
        return 1'b1;
    endfunction

    initial begin : stim
        rst      = 1'b1;
        start_v  = '0;
        a_v      = '0;
        b_v      = '0;
        cin_v    = '0;
        chk_en   = 1'b0;
        end_req  = 1'b0;
        lit_wr   = 0;
        tmo_cnt  = 0;
        zchk_cyc = -1;

        repeat (3) step();
        zchk_cyc = cyc;
        chk_en   = 1'b1;
        rst      = 1'b0;
        step();

        // Arithmetic corner cases on the WIDTH=8, CHUNK=2 instance.
        do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);
        do_op(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);

        // A start pulse with new operands in the middle of RUN must be ignored.
        launch(8'h01, 8'h02, 1'b0);
        expect_lit(8'h03, 1'b0, 1'b0);
        step();
        start_v[DIRG] = 1'b0;
        step();
        launch(8'h11, 8'h22, 1'b0);
        step();
        start_v[DIRG] = 1'b0;
        wait_done();
        step();

        // Back-to-back: start held in the DONE cycle goes straight into RUN.
        launch(8'h10, 8'h20, 1'b0);
        expect_lit(8'h30, 1'b0, 1'b0);
        step();
        start_v[DIRG] = 1'b0;
        wait_done();
        launch(8'hC0, 8'h50, 1'b0);
        expect_lit(8'h10, 1'b1, 1'b0);
        step();
        start_v[DIRG] = 1'b0;
        wait_done();
        step();

        // Reset during the second RUN cycle aborts the operation with no done pulse.
        launch(8'h33, 8'h44, 1'b0);
        step();
        start_v[DIRG] = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        zchk_cyc = cyc;
        repeat (8) step();
        do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

        // Random phase on every configuration at once.
        begin : rand_phase
            int k;
            k = 0;
            while (k < RAND_LIMIT && !all_ops_done()) begin
                for (int g = 0; g < NCFG; g++) begin
                    start_v[g] = (ops[g] < NOPS) && ($urandom_range(0, 1) == 1);
                    a_v[g]     = ($urandom_range(0, 7) == 0) ? '1 : MAXW'($urandom);
                    b_v[g]     = ($urandom_range(0, 7) == 0) ? '1 : MAXW'($urandom);
                    cin_v[g]   = 1'($urandom_range(0, 1));
                end
                step();
                k++;
            end
        end
        start_v = '0;
        repeat (20) step();
        end_req = 1'b1;
        repeat (4) step();
        $display("FAIL summary_not_reached");
        $fatal(1);
    end

endmodule
